// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and constants for the serial comparator service
package cmp_pkg;

   localparam int CMP_N     = 32;
   localparam int CMP_SLICE = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_e;

   typedef struct packed {
      logic [CMP_N-1:0] a;
      logic [CMP_N-1:0] b;
      logic             is_signed;
   } cmp_req_t;

endpackage

// File: rtl/cmp_slice.sv
// rtl/cmp_slice.sv - combinational unsigned less-than/equal on one operand slice
module cmp_slice
   import cmp_pkg::*;
#(
   parameter int W = CMP_SLICE
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         lt,
   output logic         eq
);

   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/cmp_serial_arb.sv
// rtl/cmp_serial_arb.sv - two-requester round-robin arbiter over a slice-serial comparator
// CMP_EARLY_EXIT_EN: stop at the first differing slice instead of always walking all slices.
module cmp_serial_arb
   import cmp_pkg::*;
#(
   parameter int N     = CMP_N,
   parameter int SLICE = CMP_SLICE
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         req0_valid_i,
   output logic         req0_ready_o,
   input  logic [N-1:0] req0_a_i,
   input  logic [N-1:0] req0_b_i,
   input  logic         req0_signed_i,
   input  logic         req1_valid_i,
   output logic         req1_ready_o,
   input  logic [N-1:0] req1_a_i,
   input  logic [N-1:0] req1_b_i,
   input  logic         req1_signed_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic         rsp_id_o,
   output logic         rsp_lt_o,
   output logic         rsp_eq_o
);

   localparam int NSLICE = N / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(NSLICE - 1);

   cmp_state_e    state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic [N-1:0]  opA, opANext, opB, opBNext;
   logic          rrLast, rrLastNext;
   logic          rspId, rspIdNext, rspLt, rspLtNext, rspEq, rspEqNext;
   logic          grant0, grant1;
   logic          sliceLt, sliceEq;
   cmp_req_t      selReq;
`ifndef CMP_EARLY_EXIT_EN
   logic          decided, decidedNext;
`endif

   // Operands shift left each step so the slice under test always sits at the MSB end.
   cmp_slice #(.W(SLICE)) uSlice (
      .a  (opA[N-1 -: SLICE]),
      .b  (opB[N-1 -: SLICE]),
      .lt (sliceLt),
      .eq (sliceEq)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= IDLE;
         cnt     <= CNT_TOP;
         opA     <= '0;
         opB     <= '0;
         rrLast  <= 1'b1;
         rspId   <= 1'b0;
         rspLt   <= 1'b0;
         rspEq   <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
         decided <= 1'b0;
`endif
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         opA     <= opANext;
         opB     <= opBNext;
         rrLast  <= rrLastNext;
         rspId   <= rspIdNext;
         rspLt   <= rspLtNext;
         rspEq   <= rspEqNext;
`ifndef CMP_EARLY_EXIT_EN
         decided <= decidedNext;
`endif
      end
   end

   // Reset gates the grant so no ready escapes while rst_ni is low.
   assign grant0 = rst_ni && req0_valid_i && (!req1_valid_i || rrLast);
   assign grant1 = rst_ni && req1_valid_i && (!req0_valid_i || !rrLast);

   always_comb begin
      selReq.a         = grant1 ? req1_a_i      : req0_a_i;
      selReq.b         = grant1 ? req1_b_i      : req0_b_i;
      selReq.is_signed = grant1 ? req1_signed_i : req0_signed_i;
   end

   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      opANext      = opA;
      opBNext      = opB;
      rrLastNext   = rrLast;
      rspIdNext    = rspId;
      rspLtNext    = rspLt;
      rspEqNext    = rspEq;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      decidedNext  = decided;
`endif
      case (state)
         IDLE: begin
            if (grant0 || grant1) begin
               req0_ready_o = grant0;
               req1_ready_o = grant1;
               // Flipping the sign bit maps signed order onto unsigned order.
               opANext      = selReq.a ^ {selReq.is_signed, {(N-1){1'b0}}};
               opBNext      = selReq.b ^ {selReq.is_signed, {(N-1){1'b0}}};
               rspIdNext    = grant1;
               rrLastNext   = grant1;
               cntNext      = CNT_TOP;
`ifndef CMP_EARLY_EXIT_EN
               decidedNext  = 1'b0;
`endif
               stateNext    = RUN;
            end
         end
         RUN: begin
            opANext = opA << SLICE;
            opBNext = opB << SLICE;
`ifdef CMP_EARLY_EXIT_EN
            if (!sliceEq) begin
               rspLtNext = sliceLt;
               rspEqNext = 1'b0;
               stateNext = DONE;
            end else if (cnt == '0) begin
               rspLtNext = 1'b0;
               rspEqNext = 1'b1;
               stateNext = DONE;
            end else begin
               cntNext = cnt - CW'(1);
            end
`else
            if (!decided && !sliceEq) begin
               decidedNext = 1'b1;
               rspLtNext   = sliceLt;
               rspEqNext   = 1'b0;
            end
            if (cnt == '0) begin
               stateNext = DONE;
               if (!decided && sliceEq) begin
                  rspLtNext = 1'b0;
                  rspEqNext = 1'b1;
               end
            end else begin
               cntNext = cnt - CW'(1);
            end
`endif
         end
         DONE: begin
            if (rsp_ready_i) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign rsp_valid_o = (state == DONE);
   assign rsp_id_o    = rspId;
   assign rsp_lt_o    = rspLt;
   assign rsp_eq_o    = rspEq;

endmodule

// File: tb/tb_cmp_serial_arb.sv
// tb/tb_cmp_serial_arb.sv - directed and randomized checks of cmp_serial_arb against a reference model
module tb_cmp_serial_arb;

   localparam int N      = 32;
   localparam int SLICE  = 4;
   localparam int NSLICE = N / SLICE;

   logic          clk = 1'b0;
   logic          rstN;
   logic          v0, v1, s0, s1;
   logic [N-1:0]  a0, b0, a1, b1;
   logic          rdy0, rdy1;
   logic          rspValid, rspReady, rspId, rspLt, rspEq;

   int errors = 0;
   int checks = 0;

   cmp_serial_arb dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .req0_valid_i  (v0),
      .req0_ready_o  (rdy0),
      .req0_a_i      (a0),
      .req0_b_i      (b0),
      .req0_signed_i (s0),
      .req1_valid_i  (v1),
      .req1_ready_o  (rdy1),
      .req1_a_i      (a1),
      .req1_b_i      (b1),
      .req1_signed_i (s1),
      .rsp_valid_o   (rspValid),
      .rsp_ready_i   (rspReady),
      .rsp_id_o      (rspId),
      .rsp_lt_o      (rspLt),
      .rsp_eq_o      (rspEq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected result straight from the arithmetic definition of the compare.
   function automatic void refModel(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                    output logic lt, output logic eq, output int lat);
      logic [N-1:0] x;
      int k;
      bit found;
      eq = (a == b);
      lt = s ? ($signed(a) < $signed(b)) : (a < b);
      x = a ^ b;
      k = NSLICE;
      found = 0;
      for (int i = 1; i <= NSLICE; i++) begin
         if (!found && ((x >> (N - SLICE * i)) & 32'hF) != 0) begin
            found = 1;
            k = i;
         end
      end
`ifdef CMP_EARLY_EXIT_EN
      lat = 1 + k;
`else
      lat = 1 + NSLICE + (k - k);
`endif
   endfunction

   task automatic waitRsp(input string tag, input int elat, input logic eid,
                          input logic elt, input logic eeq);
      int lat;
      lat = 1;
      while (!rspValid && lat < 20) begin
         @(negedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, lat, elat);
      check({tag, "_id"}, rspId, eid);
      check({tag, "_lt"}, rspLt, elt);
      check({tag, "_eq"}, rspEq, eeq);
   endtask

   task automatic runOne(input string tag, input logic id, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic s);
      logic elt, eeq;
      int elat, c;
      refModel(a, b, s, elt, eeq, elat);
      @(negedge clk);
      if (id) begin v1 = 1; a1 = a; b1 = b; s1 = s; end
      else    begin v0 = 1; a0 = a; b0 = b; s0 = s; end
      #1;
      c = 0;
      while (!(id ? rdy1 : rdy0) && c < 10) begin
         @(negedge clk); #1;
         c++;
      end
      check({tag, "_grant"}, id ? rdy1 : rdy0, 1);
      check({tag, "_other"}, id ? rdy0 : rdy1, 0);
      @(negedge clk);
      v0 = 0; v1 = 0;
      #1;
      check({tag, "_pulse"}, rdy0 | rdy1, 0);
      waitRsp(tag, elat, id, elt, eeq);
      rspReady = 1;
      @(negedge clk); #1;
      check({tag, "_drop"}, rspValid, 0);
      rspReady = 0;
   endtask

   initial begin
      logic elt, eeq, gid, expId, stable, sid, slt, seq;
      logic [N-1:0] ra, rb, m;
      int elat, c, sl;

      // Reset with both requesters already waiting
      rstN = 0; rspReady = 0;
      v0 = 1; a0 = $urandom; b0 = $urandom; s0 = 1'($urandom_range(0, 1));
      v1 = 1; a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {rspValid, rdy0, rdy1, rspId, rspLt, rspEq}, 6'b0);

      // Contention: grants must alternate starting with requester 0
      rspReady = 1;
      rstN = 1;
      #1;
      expId = 0;
      for (int g = 0; g < 4; g++) begin
         c = 0;
         while (!(rdy0 | rdy1) && c < 15) begin
            @(negedge clk); #1;
            c++;
         end
         check("cont_seen", rdy0 | rdy1, 1);
         check("cont_onehot", rdy0 & rdy1, 0);
         gid = rdy1;
         check("cont_order", gid, expId);
         if (gid) refModel(a1, b1, s1, elt, eeq, elat);
         else     refModel(a0, b0, s0, elt, eeq, elat);
         @(negedge clk);
         if (gid) begin a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(0, 1)); end
         else     begin a0 = $urandom; b0 = $urandom; s0 = 1'($urandom_range(0, 1)); end
         #1;
         check("cont_pulse", rdy0 | rdy1, 0);
         waitRsp("cont", elat, gid, elt, eeq);
         check("cont_done_noready", rdy0 | rdy1, 0);
         if (g == 3) begin v0 = 0; v1 = 0; end
         expId = !gid;
      end
      @(negedge clk);
      rspReady = 0;

      // Directed vectors
      runOne("uns_5_7", 0, 32'h0000_0005, 32'h0000_0007, 0);
      runOne("sgn_m1_1", 1, 32'hFFFF_FFFF, 32'h0000_0001, 1);
      runOne("uns_m1_1", 1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      runOne("eq_min", 0, 32'h8000_0000, 32'h8000_0000, 1);

      // Randomized: operands differing at a chosen slice to spread latencies
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         sl = $urandom_range(0, NSLICE);
         if (sl == NSLICE) begin
            rb = ra;
         end else begin
            m  = (32'h1 << (SLICE * sl)) - 1;
            rb = ra ^ (32'($urandom_range(1, 15)) << (SLICE * sl)) ^ (32'($urandom) & m);
         end
         runOne("rand", 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
      end

      // Backpressure: DONE held with both requesters waiting
      @(negedge clk);
      v0 = 1; a0 = $urandom; b0 = $urandom; s0 = 1'($urandom_range(0, 1)); v1 = 0;
      #1;
      check("bp_grant0", rdy0, 1);
      refModel(a0, b0, s0, elt, eeq, elat);
      @(negedge clk);
      v0 = 1; a0 = $urandom; b0 = $urandom; s0 = 0;
      v1 = 1; a1 = $urandom; b1 = $urandom; s1 = 1;
      #1;
      waitRsp("bp_first", elat - 1 + 1, 0, elt, eeq);
      sid = rspId; slt = rspLt; seq = rspEq;
      stable = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (!(rspValid && rspId == sid && rspLt == slt && rspEq == seq && !rdy0 && !rdy1))
            stable = 0;
      end
      check("bp_stable", stable, 1);
      rspReady = 1;
      #1;
      check("bp_exit_noready", rdy0 | rdy1, 0);
      refModel(a1, b1, s1, elt, eeq, elat);
      @(negedge clk);
      rspReady = 0;
      #1;
      check("bp_released", rspValid, 0);
      check("bp_next_grant1", rdy1, 1);
      check("bp_next_not0", rdy0, 0);
      @(negedge clk);
      v0 = 0; v1 = 0;
      #1;
      waitRsp("bp_second", elat, 1, elt, eeq);
      rspReady = 1;
      @(negedge clk);
      rspReady = 0;

      // Reset in the third RUN cycle of an equal-operand compare
      v0 = 1; a0 = $urandom; b0 = a0; s0 = 0; v1 = 0;
      #1;
      check("rst_grant", rdy0, 1);
      repeat (3) @(negedge clk);
      rstN = 0;
      v1 = 1; a1 = $urandom; b1 = $urandom; s1 = 0;
      a0 = $urandom; b0 = $urandom; s0 = 1;
      @(negedge clk); #1;
      check("rst_mid_outputs", {rspValid, rdy0, rdy1, rspId, rspLt, rspEq}, 6'b0);
      rstN = 1;
      #1;
      check("rst_after_rdy0", rdy0, 1);
      check("rst_after_rdy1", rdy1, 0);
      refModel(a0, b0, s0, elt, eeq, elat);
      @(negedge clk);
      v0 = 0; v1 = 0;
      #1;
      waitRsp("rst_after", elat, 0, elt, eeq);
      rspReady = 1;
      @(negedge clk);
      rspReady = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
